mem_port_arbiter: RTL

Shares the core's single unified memory port between the instruction-fetch requester (port 0) and the load/store requester (port 1) of the multicycle controller. Accepts one transaction at a time using round-robin priority, drives the memory-side handshake, and returns the read data or write acknowledge to the owning requester. A watchdog converts a missing memory response into an error response so the control FSM never hangs.

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_port_arbiter_if.sv | 35 +++
 rtl/mem_port_arbiter_rr_pick2.sv | 13 +
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_port_arbiter_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;
   localparam int STRB_W = 4;
   localparam int CNT_W  = 8;

   localparam logic PORT_IFETCH = 1'b0;
   localparam logic PORT_LSU    = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_e;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [STRB_W-1:0] wstrb;
   } txn_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side signals of the arbiter; slave = arbiter view.
interface mem_port_arbiter_if;
   import mem_port_arbiter_pkg::*;

   logic              req0, req1;
   logic              we0, we1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic [STRB_W-1:0] wstrb0, wstrb1;
   logic              gnt0, gnt1;
   logic              rvalid0, rvalid1;
   logic [DATA_W-1:0] rdata0, rdata1;
   logic              err0, err1;
   logic              mem_req, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [STRB_W-1:0] mem_wstrb;
   logic              mem_ready, mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, wstrb0, wstrb1,
      input  mem_ready, mem_rvalid, mem_rdata,
      output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, wstrb0, wstrb1,
      output mem_ready, mem_rvalid, mem_rdata,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
   );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational 2-way round-robin pick; on a tie the port not served last wins.
module rr_pick2 (
   input  logic req0_i,
   input  logic req1_i,
   input  logic last_i,
   output logic sel_o,
   output logic any_o
);

   assign any_o = req0_i | req1_i;
   assign sel_o = (req0_i & req1_i) ? ~last_i : req1_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (port 0) and load/store (port 1).
// state | meaning
// IDLE  | no transaction, arbitrate incoming requests
// REQ   | mem_req held with latched fields until mem_ready
// WAIT  | awaiting mem_rvalid, watchdog counting toward TIMEOUT
module mem_port_arbiter #(
   parameter int TIMEOUT = 64
) (
   input logic              clk,
   input logic              rst,
   mem_port_arbiter_if.slave bus
);
   import mem_port_arbiter_pkg::*;

   localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

   state_e                        state_q, state_d;
   logic [CNT_W-1:0]              cnt_q, cnt_d;
   logic                          last_q, last_d;
   logic                          owner_q, owner_d;
   txn_t                          txn_q, txn_d;
   logic                          mem_req_q, mem_req_d;
   logic [1:0]                    gnt_q, gnt_d;
   logic [1:0]                    rvalid_q, rvalid_d;
   logic [1:0]                    err_q, err_d;
   logic [1:0][DATA_W-1:0]        rdata_q, rdata_d;
   logic                          sel, any;

   rr_pick2 u_pick (
      .req0_i (bus.req0),
      .req1_i (bus.req1),
      .last_i (last_q),
      .sel_o  (sel),
      .any_o  (any)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         last_q    <= 1'b1;
         owner_q   <= 1'b0;
         txn_q     <= '0;
         mem_req_q <= 1'b0;
         gnt_q     <= '0;
         rvalid_q  <= '0;
         err_q     <= '0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
         owner_q   <= owner_d;
         txn_q     <= txn_d;
         mem_req_q <= mem_req_d;
         gnt_q     <= gnt_d;
         rvalid_q  <= rvalid_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      owner_d   = owner_q;
      txn_d     = txn_q;
      mem_req_d = mem_req_q;
      gnt_d     = '0;
      rvalid_d  = '0;
      err_d     = '0;
      rdata_d   = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (any) begin
               owner_d     = sel;
               txn_d.we    = sel ? bus.we1    : bus.we0;
               txn_d.addr  = sel ? bus.addr1  : bus.addr0;
               txn_d.wdata = sel ? bus.wdata1 : bus.wdata0;
               txn_d.wstrb = sel ? bus.wstrb1 : bus.wstrb0;
               gnt_d[sel]  = 1'b1;
               mem_req_d   = 1'b1;
               state_d     = ST_REQ;
            end
         end
         ST_REQ: begin
            if (bus.mem_ready) begin
               mem_req_d = 1'b0;
               cnt_d     = '0;
               last_d    = owner_q;
               state_d   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            // A response landing on the terminal count still beats the watchdog.
            if (bus.mem_rvalid) begin
               rvalid_d[owner_q] = 1'b1;
               rdata_d[owner_q]  = txn_q.we ? '0 : bus.mem_rdata;
               state_d           = ST_IDLE;
            end else if (cnt_q == TO_CNT) begin
               rvalid_d[owner_q] = 1'b1;
               err_d[owner_q]    = 1'b1;
               state_d           = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.gnt0      = gnt_q[PORT_IFETCH];
   assign bus.gnt1      = gnt_q[PORT_LSU];
   assign bus.rvalid0   = rvalid_q[PORT_IFETCH];
   assign bus.rvalid1   = rvalid_q[PORT_LSU];
   assign bus.err0      = err_q[PORT_IFETCH];
   assign bus.err1      = err_q[PORT_LSU];
   assign bus.rdata0    = rdata_q[PORT_IFETCH];
   assign bus.rdata1    = rdata_q[PORT_LSU];
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = txn_q.we;
   assign bus.mem_addr  = txn_q.addr;
   assign bus.mem_wdata = txn_q.wdata;
   assign bus.mem_wstrb = txn_q.wstrb;

endmodule
